jtag_tap_responder: RTL
=======================

Name: jtag_tap_responder

Overview:
- Target-side JTAG TAP responder: receives TCK/TMS/TDI/nTRST from the probe's buffered JTAG outputs, returns TDO and RTCK.
- Oversamples the JTAG pins on the system clock, runs the IEEE 1149.1 16-state TAP FSM, and implements IR, IDCODE and BYPASS registers.
- Used as an on-board loopback target for probe self-test and as a CPLD-resident debug TAP.

Parameters:
- IR_W, 4, instruction register width (>=2).
- IDCODE_VAL, 32'h1BB0_0001, value captured in IDCODE DR; bit 0 must be 1.
- IR_IDCODE, 4'b0001, IDCODE opcode (IR_W bits).
- USER_W, 8, width of USER data register (optional feature only).

Ports:
- CLK  in  1  system clock; >=6x TCK frequency.
- RST  in  1  synchronous active-high reset.
- TCK  in  1  JTAG clock from probe, async.
- TMS  in  1  JTAG mode select, async.
- TDI  in  1  JTAG data in, async.
- nTRST  in  1  JTAG TAP reset, active-low, async.
- TDO  out  1  JTAG data out to probe.
- TDO_OE  out  1  high while TDO is valid (Shift-DR/Shift-IR).
- RTCK  out  1  returned clock = synchronized TCK.
- TAP_STATE  out  4  current TAP state (encoding below).
- IR_OUT  out  IR_W  current active instruction.
- UPDATE_DR  out  1  one-CLK pulse when entering Update-DR.

Behaviour:
- Sync: TCK, TMS, TDI, nTRST each pass 2 FF stages. An extra TCK stage gives edge detect. tck_rise = s2&~s3; tck_fall = ~s2&s3. Pin-to-event latency is 3 CLK. TCK high and low time must each be >=3 CLK.
- RTCK = TCK sync stage 3. Reset value 0.
- State encoding:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5.
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
- FSM advances only on tck_rise, using synchronized TMS, per the standard 1149.1 transition table.
- Actions on the tck_rise that leaves a state, evaluated on the current state:
  - CapIR: ir_shift <= {0..,01}.
  - ShIR: ir_shift <= {TDI, ir_shift[IR_W-1:1]}.
  - CapDR: dr_shift <= IDCODE_VAL if IR=IR_IDCODE, else 0 (bypass).
  - ShDR: shift right with TDI into the MSB of the selected length (32 for IDCODE, 1 for bypass).
- Entering UpdIR: IR_OUT <= ir_shift.
- Entering UpdDR: UPDATE_DR pulses for 1 CLK, coincident with the state change.
- Decode: IR=IR_IDCODE selects IDCODE. All-ones and every other opcode select BYPASS.
- TDO and TDO_OE update only on tck_fall:
  - ShDR: TDO <= dr_shift[0], TDO_OE <= 1.
  - ShIR: TDO <= ir_shift[0], TDO_OE <= 1.
  - Else: TDO_OE <= 0 and TDO holds its last value.
- Reset, when RST=1 or synchronized nTRST=0:
  - TAP_STATE=F, IR_OUT=IR_IDCODE, ir_shift=0, dr_shift=0.
  - TDO=0, TDO_OE=0, UPDATE_DR=0.
  - RST additionally clears all synchronizers; RTCK=0.
  - nTRST does not clear synchronizers.
- RST/nTRST asserted mid-shift: partial shift data is discarded and IR_OUT is not updated.
- Entering TLR via TMS: IR_OUT <= IR_IDCODE.
- tck_rise and tck_fall can never coincide (guaranteed by the edge detect). An event arriving in the same CLK as RST is ignored.
- Five consecutive tck_rise with TMS=1 reach TLR from any state.

Optional Feature:
- Macro: JTAG_USER_DR_EN.
- Defined:
  - Opcode IR_W'b0010 selects a USER_W-bit USER DR.
  - CapDR loads the held user_reg.
  - UpdDR copies dr_shift[USER_W-1:0] into user_reg.
  - Adds output port USER_REG [USER_W-1:0], reset 0.
- Undefined: opcode 0010 behaves as BYPASS and no USER_REG port exists.

Test Plan:
1. RST pulse, then TCK idle -> TAP_STATE=F, IR_OUT=0001, TDO_OE=0, RTCK=0.
2. From TLR, TMS 0,1,0,0, then 32 ShDR clocks (TMS=1 on the last) -> TDO bits LSB-first = 0x1BB00001, TDO_OE=1 only for those 32 falls, end state Ex1DR (1).
3. Load IR=1111 via ShIR, then shift DR pattern 1,0,1,1,0 -> TDO shows 0 (captured bypass bit) then 1,0,1,1 (1-bit delay); after UpdDR, UPDATE_DR pulses exactly once.
4. Read IR: CapIR then 4 ShIR clocks -> TDO = 1,0,0,0 (captured 01 pattern, LSB-first).
5. In ShDR mid-IDCODE, drive nTRST=0 for 4 CLK -> TAP_STATE=F, IR_OUT=0001 within 3 CLK, TDO_OE=0. Separately: 5 TMS=1 clocks from PauseIR (B) -> F.
6. JTAG_USER_DR_EN defined: IR=0010, shift 0xA5 through DR, UpdDR -> USER_REG=0xA5; second shift returns 0xA5 on TDO. Undefined: the same sequence behaves as BYPASS.

Source files
------------

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: target-side JTAG TAP. Oversamples TCK/TMS/TDI/nTRST on
// CLK, runs the 16-state 1149.1 TAP FSM and implements IR, IDCODE and BYPASS.
// Optional feature macro: JTAG_USER_DR_EN adds a USER_W-bit USER data
// register (opcode 2) and the USER_REG output port.
module jtag_tap_responder #(
    parameter int              IR_W       = 4,
    parameter logic [31:0]     IDCODE_VAL = 32'h1BB0_0001,
    parameter logic [IR_W-1:0] IR_IDCODE  = {{(IR_W-1){1'b0}}, 1'b1},
    parameter int              USER_W     = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            TCK,
    input  logic            TMS,
    input  logic            TDI,
    input  logic            nTRST,
    output logic            TDO,
    output logic            TDO_OE,
    output logic            RTCK,
    output logic [3:0]      TAP_STATE,
    output logic [IR_W-1:0] IR_OUT,
    output logic            UPDATE_DR
`ifdef JTAG_USER_DR_EN
    ,
    output logic [USER_W-1:0] USER_REG
`endif
);

    // DR shifter is wide enough for IDCODE and for the USER register
    localparam int DR_W = (USER_W > 32) ? USER_W : 32;

    typedef enum logic [3:0] {
        S_TLR     = 4'hF, S_RTI     = 4'hC,
        S_SELDR   = 4'h7, S_CAPDR   = 4'h6, S_SHDR    = 4'h2, S_EX1DR   = 4'h1,
        S_PAUSEDR = 4'h3, S_EX2DR   = 4'h0, S_UPDDR   = 4'h5,
        S_SELIR   = 4'h4, S_CAPIR   = 4'hE, S_SHIR    = 4'hA, S_EX1IR   = 4'h9,
        S_PAUSEIR = 4'hB, S_EX2IR   = 4'h8, S_UPDIR   = 4'hD
    } tap_state_t;

    logic r_tck_s1, r_tck_s2, r_tck_s3;
    logic r_tms_s1, r_tms_s2;
    logic r_tdi_s1, r_tdi_s2;
    logic r_ntrst_s1, r_ntrst_s2;

    tap_state_t      r_state, w_next;
    logic [IR_W-1:0] r_ir_shift, r_ir_out;
    logic [DR_W-1:0] r_dr_shift, w_dr_shifted, w_dr_capture;
    logic            r_tdo, r_tdo_oe, r_update_dr;
    logic            w_rise, w_fall, w_tap_rst, w_sel_idcode, w_sel_user;

`ifdef JTAG_USER_DR_EN
    localparam logic [IR_W-1:0] IR_USER = IR_W'(2);
    logic [USER_W-1:0] r_user_reg;
    assign w_sel_user = (r_ir_out == IR_USER);
    assign USER_REG   = r_user_reg;
`else
    assign w_sel_user = 1'b0;
`endif

    assign w_rise       = r_tck_s2 & ~r_tck_s3;
    assign w_fall       = ~r_tck_s2 & r_tck_s3;
    assign w_tap_rst    = RST | ~r_ntrst_s2;
    assign w_sel_idcode = (r_ir_out == IR_IDCODE);

    assign TDO       = r_tdo;
    assign TDO_OE    = r_tdo_oe;
    assign RTCK      = r_tck_s3;
    assign TAP_STATE = r_state;
    assign IR_OUT    = r_ir_out;
    assign UPDATE_DR = r_update_dr;

    // Pin synchronizers; only RST clears them so nTRST cannot fake a TCK edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            {r_tck_s1, r_tck_s2, r_tck_s3} <= '0;
            {r_tms_s1, r_tms_s2}           <= '0;
            {r_tdi_s1, r_tdi_s2}           <= '0;
            {r_ntrst_s1, r_ntrst_s2}       <= '0;
        end else begin
            {r_tck_s1, r_tck_s2, r_tck_s3} <= {TCK, r_tck_s1, r_tck_s2};
            {r_tms_s1, r_tms_s2}           <= {TMS, r_tms_s1};
            {r_tdi_s1, r_tdi_s2}           <= {TDI, r_tdi_s1};
            {r_ntrst_s1, r_ntrst_s2}       <= {nTRST, r_ntrst_s1};
        end
    end

    // TAP state register
    always_ff @(posedge CLK) begin
        if (w_tap_rst) r_state <= S_TLR;
        else           r_state <= w_next;
    end

    // 1149.1 transition table, stepped only on a synchronized TCK rise
    always_comb begin
        w_next = r_state;
        if (w_rise) begin
            case (r_state)
                S_TLR:     w_next = r_tms_s2 ? S_TLR     : S_RTI;
                S_RTI:     w_next = r_tms_s2 ? S_SELDR   : S_RTI;
                S_SELDR:   w_next = r_tms_s2 ? S_SELIR   : S_CAPDR;
                S_CAPDR:   w_next = r_tms_s2 ? S_EX1DR   : S_SHDR;
                S_SHDR:    w_next = r_tms_s2 ? S_EX1DR   : S_SHDR;
                S_EX1DR:   w_next = r_tms_s2 ? S_UPDDR   : S_PAUSEDR;
                S_PAUSEDR: w_next = r_tms_s2 ? S_EX2DR   : S_PAUSEDR;
                S_EX2DR:   w_next = r_tms_s2 ? S_UPDDR   : S_SHDR;
                S_UPDDR:   w_next = r_tms_s2 ? S_SELDR   : S_RTI;
                S_SELIR:   w_next = r_tms_s2 ? S_TLR     : S_CAPIR;
                S_CAPIR:   w_next = r_tms_s2 ? S_EX1IR   : S_SHIR;
                S_SHIR:    w_next = r_tms_s2 ? S_EX1IR   : S_SHIR;
                S_EX1IR:   w_next = r_tms_s2 ? S_UPDIR   : S_PAUSEIR;
                S_PAUSEIR: w_next = r_tms_s2 ? S_EX2IR   : S_PAUSEIR;
                S_EX2IR:   w_next = r_tms_s2 ? S_UPDIR   : S_SHIR;
                S_UPDIR:   w_next = r_tms_s2 ? S_SELDR   : S_RTI;
                default:   w_next = S_TLR;
            endcase
        end
    end

    // DR capture value and one-bit shift of the selected length
    always_comb begin
        w_dr_capture = '0;
        if (w_sel_idcode) w_dr_capture = DR_W'(IDCODE_VAL);
`ifdef JTAG_USER_DR_EN
        else if (w_sel_user) w_dr_capture = DR_W'(r_user_reg);
`endif
        w_dr_shifted    = r_dr_shift;
        w_dr_shifted[0] = r_tdi_s2;
        if (w_sel_idcode) begin
            w_dr_shifted     = r_dr_shift >> 1;
            w_dr_shifted[31] = r_tdi_s2;
        end else if (w_sel_user) begin
            w_dr_shifted             = r_dr_shift >> 1;
            w_dr_shifted[USER_W-1]   = r_tdi_s2;
        end
    end

    // Shift registers, IR update, UPDATE_DR pulse and TDO launch
    always_ff @(posedge CLK) begin
        if (w_tap_rst) begin
            r_ir_shift  <= '0;
            r_dr_shift  <= '0;
            r_ir_out    <= IR_IDCODE;
            r_tdo       <= 1'b0;
            r_tdo_oe    <= 1'b0;
            r_update_dr <= 1'b0;
`ifdef JTAG_USER_DR_EN
            r_user_reg  <= '0;
`endif
        end else begin
            r_update_dr <= w_rise && (w_next == S_UPDDR);
            if (w_rise) begin
                case (r_state)
                    S_CAPIR: r_ir_shift <= IR_W'(1);
                    S_SHIR:  r_ir_shift <= {r_tdi_s2, r_ir_shift[IR_W-1:1]};
                    S_CAPDR: r_dr_shift <= w_dr_capture;
                    S_SHDR:  r_dr_shift <= w_dr_shifted;
                    default: ;
                endcase
                // Ex1IR/Ex2IR leave ir_shift untouched, so it is current here
                if (w_next == S_UPDIR)     r_ir_out <= r_ir_shift;
                else if (w_next == S_TLR)  r_ir_out <= IR_IDCODE;
`ifdef JTAG_USER_DR_EN
                if (w_next == S_UPDDR && w_sel_user)
                    r_user_reg <= r_dr_shift[USER_W-1:0];
`endif
            end
            if (w_fall) begin
                if (r_state == S_SHDR) begin
                    r_tdo    <= r_dr_shift[0];
                    r_tdo_oe <= 1'b1;
                end else if (r_state == S_SHIR) begin
                    r_tdo    <= r_ir_shift[0];
                    r_tdo_oe <= 1'b1;
                end else begin
                    r_tdo_oe <= 1'b0;
                end
            end
        end
    end

endmodule
